renas_ahb_mem: RTL

Parametrised multi-port AHB-Lite slave memory for the renas MCU, the successor of the fixed dual-port instruction/data main memory. It exposes NUM_PORTS independent AHB-Lite slave ports onto one word-organised SRAM array. It adds configurable wait states, byte/halfword writes, base-address relocation, and ERROR responses for illegal accesses. It sits behind the AHB interconnect, with port 0 on the I-bus and port 1 on the D-bus in the default build.

---
 rtl/renas_ahb_mem.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/renas_ahb_mem.sv
// renas_ahb_mem: multi-port AHB-Lite slave memory.
// NUM_PORTS independent ports share one word SRAM.
module renas_ahb_mem #(
  parameter int          NUM_PORTS   = 2,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          WAIT_STATES = 0
) (
  input  logic                    clk_mem,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    hsel,
  input  logic [32*NUM_PORTS-1:0] haddr,
  input  logic [2*NUM_PORTS-1:0]  htrans,
  input  logic [NUM_PORTS-1:0]    hwrite,
  input  logic [3*NUM_PORTS-1:0]  hsize,
  input  logic [32*NUM_PORTS-1:0] hwdata,
  input  logic [NUM_PORTS-1:0]    hready,
  output logic [NUM_PORTS-1:0]    hreadyout,
  output logic [NUM_PORTS-1:0]    hresp,
  output logic [32*NUM_PORTS-1:0] hrdata
);

  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIM =
    {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [2:0] WLAST =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } st_t;

  logic [31:0]             mem [DEPTH];
  logic [NUM_PORTS-1:0]    wen;
  logic [4*NUM_PORTS-1:0]  wbe;
  logic [AW*NUM_PORTS-1:0] widx;
  logic                    unused_trans;

  // htrans[0] (SEQ vs NONSEQ) does not change behaviour
  assign unused_trans = ^htrans;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [31:0]   a;
    logic [2:0]    sz;
    logic          acc;
    logic          bad;
    logic          lat;
    logic [3:0]    be;
    logic [AW-1:0] idx;
    st_t           st_q;
    st_t           st_d;
    st_t           st_acc;
    logic [2:0]    cnt_q;
    logic [2:0]    cnt_d;
    logic [AW-1:0] idx_q;
    logic [3:0]    be_q;
    logic          wr_q;

    assign a   = haddr[p*32 +: 32];
    assign sz  = hsize[p*3 +: 3];
    assign acc = hsel[p] && htrans[p*2+1]
              && hready[p];
    assign idx = AW'((a - BASE_ADDR) >> 2);

    // classify the address phase as illegal
    always_comb begin
      bad = ({1'b0, a} < {1'b0, BASE_ADDR})
         || ({1'b0, a} >= LIM)
         || (sz > 3'd2)
         || (sz == 3'd1 && a[0])
         || (sz == 3'd2 && a[1:0] != 2'b00);
    end

    // byte-enable from size and lane
    always_comb begin
      be = 4'hF;
      unique case (sz)
        3'd0:    be = 4'b0001 << a[1:0];
        3'd1:    be = 4'b0011 << a[1:0];
        default: be = 4'hF;
      endcase
    end

    // next state; IDLE/DATA/ERR2 take new accepts
    always_comb begin
      st_acc = S_IDLE;
      if (acc) begin
        if (bad)
          st_acc = S_ERR1;
        else if (WAIT_STATES > 0)
          st_acc = S_WAIT;
        else
          st_acc = S_DATA;
      end
      st_d  = st_q;
      cnt_d = cnt_q;
      lat   = 1'b0;
      unique case (st_q)
        S_WAIT: begin
          if (cnt_q == WLAST)
            st_d = S_DATA;
          else
            cnt_d = cnt_q + 3'd1;
        end
        S_ERR1:  st_d = S_ERR2;
        default: begin
          st_d  = st_acc;
          cnt_d = 3'd0;
          lat   = acc;
        end
      endcase
    end

    // state and latched address-phase controls
    always_ff @(posedge clk_mem) begin
      if (rst) begin
        st_q  <= S_IDLE;
        cnt_q <= '0;
        idx_q <= '0;
        be_q  <= '0;
        wr_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        if (lat) begin
          idx_q <= idx;
          be_q  <= be;
          wr_q  <= hwrite[p];
        end
      end
    end

    assign hreadyout[p] = (st_q != S_WAIT)
                       && (st_q != S_ERR1);
    assign hresp[p] = (st_q == S_ERR1)
                   || (st_q == S_ERR2);
    assign hrdata[p*32 +: 32] =
      (st_q == S_DATA && !wr_q) ? mem[idx_q] : 32'h0;
    assign wen[p] = (st_q == S_DATA) && wr_q;
    assign wbe[p*4 +: 4] = be_q;
    assign widx[p*AW +: AW] = idx_q;
  end

  // commit writes; lower port applied last so it wins
  always_ff @(posedge clk_mem) begin
    if (!rst) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (wen[p]) begin
          for (int l = 0; l < 4; l++) begin
            if (wbe[p*4 + l])
              mem[widx[p*AW +: AW]][l*8 +: 8] <=
                hwdata[p*32 + l*8 +: 8];
          end
        end
      end
    end
  end

endmodule
